multicycle_control: RTL and testbench

//  Main FSM of the multi-cycle RV32I core: sequences fetch, decode, execute, memory and write-back over one

---
 rtl/multicycle_control_pkg.sv | 154 +++++++++++++++
 rtl/multicycle_control_mem_wait_timer.sv | 32 +++
 rtl/multicycle_control.sv | 143 ++++++++++++++
 tb/tb_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM.
//  - OP_*      : RV32I major opcodes (IR[6:0])
//  - state_t   : FSM state encoding
//  - ALU_OP_*, RES_*, SRCA_*, SRCB_*, CAUSE_* : select / cause codes
//  - ctl_t     : the Moore part of the datapath control word
//  - state_ctl : Moore control word for a given state
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWR,
    ST_MEMWB,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_LUI,
    ST_AUIPC,
    ST_ALUWB,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_PC     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // pc_write here is only the unconditional strobe (JUMP); the FETCH and
  // BRANCH strobes depend on live inputs and are added in the top.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       pc_src;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  // is_jal only matters in ST_JUMP: JAL takes the target from ALUOut
  // (computed in DECODE), JALR computes rs1+imm in this cycle.
  function automatic ctl_t state_ctl(input state_t st, input logic is_jal);
    ctl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_OP_ADD;
      end
      ST_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      ST_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_MEM;
      end
      ST_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_OP_FUNCT;
      end
      ST_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_OP_FUNCT;
      end
      ST_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
      end
      ST_AUIPC: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      ST_ALUWB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_OP_SUB;
        c.pc_src    = 1'b1;
      end
      ST_JUMP: begin
        // link value is PC, already advanced by 4 in FETCH
        c.reg_write  = 1'b1;
        c.result_src = RES_PC;
        c.pc_write   = 1'b1;
        if (is_jal) begin
          c.pc_src = 1'b1;
        end else begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_OP_ADD;
          c.pc_src    = 1'b0;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles in which a request is
// outstanding and not completed. expire is asserted during the cycle that
// would be the MEM_TIMEOUT-th such wait cycle; a completion in that cycle
// means waiting=0, so completion always wins. MEM_TIMEOUT=0 disables expiry.
//  clk, rst_n : clock, async active-low reset
//  waiting    : mem_req=1 and mem_ready=0 this cycle
//  expire     : limit reached this cycle (combinational)
module multicycle_control_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic expire
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TW-1:0] cnt;

  // Clears on any non-waiting cycle: that covers completion and leaving
  // the requesting state (non-request states never assert waiting).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (waiting && !expire) cnt <= cnt + 1'b1;
    else                        cnt <= '0;
  end

  assign expire = (MEM_TIMEOUT > 0) && waiting && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core. Sequences fetch, decode,
// execute, memory and write-back over one ALU and one memory port.
//  clk, rst_n          : clock, async active-low reset
//  opcode              : IR[6:0], stable after FETCH
//  branch_taken        : branch comparator result
//  mem_ready           : memory completes current request
//  mem_req/mem_we/adr_src : memory request handshake, held until mem_ready
//  ir_write/pc_write/pc_src/reg_write/result_src : datapath strobes/selects
//  alu_src_a/alu_src_b/alu_op : ALU operand selects and op class
//  instret             : retired-instruction count (wraps)
//  fault/fault_cause   : sticky fault flag and cause
// Control outputs are registered from the next state (Moore); only
// ir_write/pc_write in FETCH and pc_write in BRANCH follow live inputs.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [1:0]       fault_cause
);

  state_t     state, state_nxt;
  ctl_t       ctl;
  logic       expire;
  logic       retire;
  logic [1:0] cause_nxt;

  multicycle_control_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (ctl.mem_req & ~mem_ready),
    .expire  (expire)
  );

  always_comb begin
    state_nxt = state;
    cause_nxt = fault_cause;
    retire    = 1'b0;
    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_nxt = ST_DECODE;
        end else if (expire) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = ST_MEMADR;
          OP_R_TYPE:         state_nxt = ST_EXEC_R;
          OP_IMM:            state_nxt = ST_EXEC_I;
          OP_BRANCH:         state_nxt = ST_BRANCH;
          OP_JAL, OP_JALR:   state_nxt = ST_JUMP;
          OP_LUI:            state_nxt = ST_LUI;
          OP_AUIPC:          state_nxt = ST_AUIPC;
          default: begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: state_nxt = (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        if (mem_ready) begin
          state_nxt = ST_MEMWB;
        end else if (expire) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end else if (expire) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: state_nxt = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      ctl         <= '0;
      instret     <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      state       <= state_nxt;
      ctl         <= state_ctl(state_nxt, opcode == OP_JAL);
      fault_cause <= cause_nxt;
      if (retire)               instret <= instret + 1'b1;
      if (state_nxt == ST_TRAP) fault   <= 1'b1;
    end
  end

  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign adr_src    = ctl.adr_src;
  assign pc_src     = ctl.pc_src;
  assign reg_write  = ctl.reg_write;
  assign result_src = ctl.result_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;

  // FETCH loads IR and advances PC in the completing cycle itself.
  assign ir_write = (state == ST_FETCH) & mem_ready;
  assign pc_write = ctl.pc_write | ir_write | ((state == ST_BRANCH) & branch_taken);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into the phase
// sequence the control flow prescribes; each phase has a table of expected
// outputs. Observed vs. expected cycles are queued and compared in the tests.
module tb_multicycle_control;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [6:0] T_LOAD  = 7'b0000011, T_STORE = 7'b0100011,
                         T_R     = 7'b0110011, T_IMM   = 7'b0010011,
                         T_BR    = 7'b1100011, T_JAL   = 7'b1101111,
                         T_JALR  = 7'b1100111, T_LUI   = 7'b0110111,
                         T_AUIPC = 7'b0010111;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic branch_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, fault_cause;
  logic [CW-1:0] instret;

  multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instret(instret), .fault(fault), .fault_cause(fault_cause));

  always #5 clk = ~clk;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWR, P_MEMWB,
                P_EXEC_R, P_EXEC_I, P_LUI, P_AUIPC, P_ALUWB, P_BRANCH, P_JUMP,
                P_TRAP} ph_t;

  typedef struct packed {
    logic mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] res, a, b, op;
    logic fault;
    logic [1:0] cause;
    logic [CW-1:0] instret;
  } obs_t;

  int vectors = 0, miscompares = 0;
  int m_instret = 0;
  logic m_fault = 1'b0;
  logic [1:0] m_cause = 2'b00;
  obs_t got_q[$], exp_q[$];
  ph_t  ph_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.mem_req = mem_req;   o.mem_we = mem_we;     o.adr_src = adr_src;
    o.ir_write = ir_write; o.pc_write = pc_write; o.pc_src = pc_src;
    o.reg_write = reg_write; o.res = result_src;  o.a = alu_src_a;
    o.b = alu_src_b;       o.op = alu_op;         o.fault = fault;
    o.cause = fault_cause; o.instret = instret;
    return o;
  endfunction

  // Expected outputs for one cycle of a phase.
  function automatic obs_t model(ph_t ph, logic [6:0] op, logic bt, logic mr);
    obs_t e;
    e = '0;
    e.fault = m_fault; e.cause = m_cause; e.instret = CW'(m_instret);
    case (ph)
      P_FETCH:  begin e.mem_req = 1; e.b = 2'b10; e.ir_write = mr; e.pc_write = mr; end
      P_DECODE: begin e.a = 2'b01; e.b = 2'b01; end
      P_MEMADR: begin e.a = 2'b10; e.b = 2'b01; end
      P_MEMRD:  begin e.mem_req = 1; e.adr_src = 1; end
      P_MEMWR:  begin e.mem_req = 1; e.adr_src = 1; e.mem_we = 1; end
      P_MEMWB:  begin e.reg_write = 1; e.res = 2'b01; end
      P_EXEC_R: begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b10; end
      P_EXEC_I: begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
      P_LUI:    begin e.a = 2'b11; e.b = 2'b01; end
      P_AUIPC:  begin e.a = 2'b01; e.b = 2'b01; end
      P_ALUWB:  begin e.reg_write = 1; e.res = 2'b00; end
      P_BRANCH: begin e.a = 2'b10; e.b = 2'b00; e.op = 2'b01; e.pc_src = 1; e.pc_write = bt; end
      P_JUMP: begin
        e.reg_write = 1; e.res = 2'b11; e.pc_write = 1;
        if (op == T_JAL) e.pc_src = 1;
        else begin e.a = 2'b10; e.b = 2'b01; end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic do_cycle(ph_t ph, logic [6:0] op, logic bt, logic mr);
    opcode = op;
    branch_taken = (ph == P_BRANCH) ? bt : 1'($urandom);
    mem_ready = mr;
    @(negedge clk);
    got_q.push_back(sample());
    exp_q.push_back(model(ph, op, bt, mr));
    ph_q.push_back(ph);
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); ph_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_instret = 0; m_fault = 1'b0; m_cause = 2'b00;
    repeat (2) do_cycle(P_RESET, 7'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b1;
    do_cycle(P_RESET, 7'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // fw/mw: wait cycles before mem_ready in FETCH / data phase.
  // trap_n: cycles to observe in TRAP if the instruction faults.
  task automatic drive_instr(logic [6:0] op, logic bt, int fw, int mw, int trap_n);
    ph_t p[$];
    bit legal;
    int wt;
    bit mr;
    legal = 1;
    p.push_back(P_FETCH); p.push_back(P_DECODE);
    case (op)
      T_LOAD:  begin p.push_back(P_MEMADR); p.push_back(P_MEMRD); p.push_back(P_MEMWB); end
      T_STORE: begin p.push_back(P_MEMADR); p.push_back(P_MEMWR); end
      T_R:     begin p.push_back(P_EXEC_R); p.push_back(P_ALUWB); end
      T_IMM:   begin p.push_back(P_EXEC_I); p.push_back(P_ALUWB); end
      T_LUI:   begin p.push_back(P_LUI);    p.push_back(P_ALUWB); end
      T_AUIPC: begin p.push_back(P_AUIPC);  p.push_back(P_ALUWB); end
      T_BR:    p.push_back(P_BRANCH);
      T_JAL, T_JALR: p.push_back(P_JUMP);
      default: legal = 0;
    endcase
    foreach (p[i]) begin
      if (p[i] == P_FETCH || p[i] == P_MEMRD || p[i] == P_MEMWR) begin
        wt = (p[i] == P_FETCH) ? fw : mw;
        for (int w = 0; w <= wt; w++) begin
          mr = (w == wt);
          do_cycle(p[i], op, bt, mr);
          if (!mr && w == TMO - 1) begin
            m_fault = 1'b1; m_cause = 2'b10;
            repeat (trap_n) do_cycle(P_TRAP, op, bt, 1'($urandom));
            return;
          end
        end
      end else begin
        do_cycle(p[i], op, bt, 1'($urandom));
      end
    end
    if (legal) m_instret++;
    else begin
      m_fault = 1'b1; m_cause = 2'b01;
      repeat (trap_n) do_cycle(P_TRAP, op, bt, 1'($urandom));
    end
  endtask

  task automatic test_reset();
    clear_q();
    do_reset();
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addi();
    clear_q();
    do_reset();
    drive_instr(T_IMM, 0, 0, 0, 0);
    do_cycle(P_FETCH, T_IMM, 0, 0);  // instret now 1, back in FETCH
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL addi cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load_store_wait();
    clear_q();
    do_reset();
    drive_instr(T_LOAD, 0, 0, 3, 0);
    drive_instr(T_STORE, 0, 2, 3, 0);
    drive_instr(T_LOAD, 0, TMO - 1, TMO - 1, 0);  // completion on the limit cycle wins
    do_cycle(P_FETCH, T_IMM, 0, 0);
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ldst_wait cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    clear_q();
    do_reset();
    drive_instr(T_BR, 1, 0, 0, 0);
    drive_instr(T_BR, 0, 0, 0, 0);
    drive_instr(T_JALR, 0, 1, 0, 0);
    drive_instr(T_JAL, 0, 0, 0, 0);
    do_cycle(P_FETCH, T_IMM, 0, 0);
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL br_jump cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    clear_q();
    do_reset();
    drive_instr(T_R, 0, 0, 0, 0);
    drive_instr(7'b0000000, 0, 0, 0, 20);
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_q();
    do_reset();
    drive_instr(T_IMM, 0, TMO, 0, 5);       // FETCH never answered
    do_reset();                             // pulse clears fault and counter
    drive_instr(T_STORE, 0, 0, 1, 0);
    drive_instr(T_LOAD, 0, 0, TMO + 2, 3);  // data phase never answered
    do_reset();
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL timeout cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_request();
    clear_q();
    do_reset();
    drive_instr(T_IMM, 0, 0, 0, 0);
    do_cycle(P_FETCH, T_LOAD, 0, 1);
    do_cycle(P_DECODE, T_LOAD, 0, 1'($urandom));
    do_cycle(P_MEMADR, T_LOAD, 0, 1'($urandom));
    do_cycle(P_MEMRD, T_LOAD, 0, 0);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, adr_src, ir_write, pc_write, reg_write} !== 6'b0) begin
      miscompares++;
      $display("FAIL mid_reset_strobes got=%b exp=000000",
               {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write});
    end
    vectors++;
    if (instret !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_instret got=%0d exp=0", instret);
    end
    @(posedge clk); #1;
    do_reset();
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mid_reset cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  // Random legal stream; more than 2^CW retirements, so instret wraps.
  task automatic test_random();
    logic [6:0] ops [9];
    ops = '{T_LOAD, T_STORE, T_R, T_IMM, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
    clear_q();
    do_reset();
    for (int n = 0; n < 40; n++)
      drive_instr(ops[$urandom_range(8)], 1'($urandom), $urandom_range(TMO - 1),
                  $urandom_range(TMO - 1), 0);
    do_cycle(P_FETCH, T_IMM, 0, 0);
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random cyc%0d %s got=%h exp=%h", i, ph_q[i].name(), got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_store_wait();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_request();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
